// File: rtl/qspi_collector.sv
// Round-robin collector: latches one ready encrypter word and serialises it MSB-first onto a QSPI bus.
// Optional feature: define COLLECTOR_HEADER_EN to prefix each word with an 8-bit {1, channel} header.
module qspi_collector #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 64,
    parameter  int LANES  = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_CH*DATA_W-1:0] i_encrypters_data,
    input  logic [NUM_CH-1:0]        i_encrypters_data_ready,
    output logic [NUM_CH-1:0]        o_encrypters_capture,
    output logic [LANES-1:0]         o_qspi_data,
    output logic                     o_qspi_sending,
    input  logic                     i_qspi_ready,
    output logic [CH_W-1:0]          o_qspi_channel
);

`ifdef COLLECTOR_HEADER_EN
    localparam int HDR_W = 8;
`else
    localparam int HDR_W = 0;
`endif
    localparam int SHIFT_W     = HDR_W + DATA_W;
    localparam int TOTAL_BEATS = SHIFT_W / LANES;
    localparam int CNT_W       = $clog2(TOTAL_BEATS + 1);

    localparam logic [0:0] S_SCAN = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]         r_state;
    logic [CH_W-1:0]    r_ptr;
    logic [CH_W-1:0]    r_channel;
    logic [SHIFT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_CH-1:0]  r_capture;
    logic [LANES-1:0]   r_data;
    logic               r_sending;

    logic               w_found;
    logic [CH_W-1:0]    w_sel;
    logic [CH_W:0]      w_cand;
    logic [NUM_CH-1:0]  w_onehot;
    logic [DATA_W-1:0]  w_word;
    logic [SHIFT_W-1:0] w_load;
    logic               w_last_beat;

    // Scan offsets from the highest down so the candidate nearest the pointer wins.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_cand = {1'b0, r_ptr} + (CH_W + 1)'(i);
            if (w_cand >= (CH_W + 1)'(NUM_CH)) begin
                w_cand = w_cand - (CH_W + 1)'(NUM_CH);
            end
            if (i_encrypters_data_ready[w_cand[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_sel] = 1'b1;
        w_word          = i_encrypters_data[w_sel*DATA_W +: DATA_W];
`ifdef COLLECTOR_HEADER_EN
        w_load          = {1'b1, 7'(w_sel), w_word};
`else
        w_load          = w_word;
`endif
    end

    assign w_last_beat = (r_cnt == CNT_W'(TOTAL_BEATS - 1));

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_SCAN;
            r_ptr     <= '0;
            r_channel <= '0;
            r_cnt     <= '0;
            r_capture <= '0;
            r_data    <= '0;
            r_sending <= 1'b0;
        end else begin
            r_capture <= '0;
            case (r_state)
                S_SCAN: begin
                    r_sending <= 1'b0;
                    if (w_found) begin
                        r_channel <= w_sel;
                        r_capture <= w_onehot;
                        r_cnt     <= '0;
                        r_state   <= S_SEND;
                    end
                end
                default: begin
                    r_sending <= i_qspi_ready;
                    if (i_qspi_ready) begin
                        r_data <= r_shift[SHIFT_W-1 -: LANES];
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_ptr   <= (r_channel == CH_W'(NUM_CH - 1)) ? '0 : r_channel + 1'b1;
                            r_state <= S_SCAN;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: the shift register is pure datapath, always reloaded before use, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (r_state == S_SCAN) begin
            if (w_found) begin
                r_shift <= w_load;
            end
        end else if (i_qspi_ready) begin
            r_shift <= r_shift << LANES;
        end
    end

    assign o_encrypters_capture = r_capture;
    assign o_qspi_data          = r_data;
    assign o_qspi_sending       = r_sending;
    assign o_qspi_channel       = r_channel;

endmodule
